// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t     : fetch FSM states (boot bubble, running, halted)
//   PC_STEP           : PC increment per fetched word
//   PC_ALIGN_MASK     : forces redirect targets onto a word boundary
//   DEFAULT_HALT_WORD : default encoding that stops fetch
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // Misaligned redirect targets are silently rounded down to a word.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// ----------------------------------------------------------------------------
// if_id_pipe_reg
// IF/ID pipeline register with flush, load and hold controls.
// Priority: flush > load > hold.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : clear the register to a bubble (all fields zero)
//   load           : capture load_instr / load_pcplus4 and mark valid
//   load_instr     : instruction word to capture
//   load_pcplus4   : PC+4 of that instruction
//   instr, pcplus4 : registered instruction and its PC+4
//   valid          : register holds a real instruction
// ----------------------------------------------------------------------------
module if_id_pipe_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pcplus4,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= '0;
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= '0;
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= load_instr;
            pcplus4 <= load_pcplus4;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures the returned word into IF/ID.
// Handles ID stalls, EX-stage redirects and a halt word.
// Parameters:
//   RESET_PC  : PC value loaded on reset
//   HALT_WORD : instruction encoding that stops fetch once captured
// Ports:
//   Clk, Rst_n        : core clock, asynchronous active-low reset
//   IM_Address        : instruction-memory address (the PC register)
//   IM_Instruction    : word returned for IM_Address
//   ID_Stall          : hold PC and IF/ID this cycle
//   Redirect_Valid    : taken branch/jump from EX
//   Redirect_Target   : new PC (word-aligned here)
//   ID_Instruction    : IF/ID instruction
//   ID_PCPlus4        : IF/ID PC+4
//   ID_Valid          : IF/ID holds a real instruction
//   Halted            : fetch stopped on HALT_WORD
// Optional (macro FETCH_PERF_CNT_EN):
//   Perf_FetchCount   : cycles that loaded a valid instruction into IF/ID
//   Perf_StallCount   : RUN cycles stalled by ID without a redirect
// ----------------------------------------------------------------------------
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [31:0] IM_Address,
    input  logic [31:0] IM_Instruction,
    input  logic        ID_Stall,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_Valid,
    output logic        Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Perf_FetchCount,
    output logic [31:0] Perf_StallCount
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         pipe_load;
    logic         pipe_flush;

    // Modulo-2^32: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4   = pc_q + PC_STEP;
    assign IM_Address = pc_q;
    assign Halted     = (state_q == ST_HALTED);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pipe_load  = 1'b0;
        pipe_flush = 1'b0;
        unique case (state_q)
            // One bubble cycle; redirect and stall are ignored here.
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Redirect_Valid) begin
                    pc_d       = align_pc(Redirect_Target);
                    pipe_flush = 1'b1;
                end else if (!ID_Stall) begin
                    pipe_load = 1'b1;
                    if (IM_Instruction == HALT_WORD) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_HALTED: begin
                if (Redirect_Valid) begin
                    // An older branch cancels the halt.
                    pc_d       = align_pc(Redirect_Target);
                    pipe_flush = 1'b1;
                    state_d    = ST_RUN;
                end else if (!ID_Stall) begin
                    // ID has taken the halt word; leave a bubble behind it.
                    pipe_flush = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    if_id_pipe_reg u_if_id (
        .clk          (Clk),
        .rst_n        (Rst_n),
        .flush        (pipe_flush),
        .load         (pipe_load),
        .load_instr   (IM_Instruction),
        .load_pcplus4 (pc_plus4),
        .instr        (ID_Instruction),
        .pcplus4      (ID_PCPlus4),
        .valid        (ID_Valid)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Perf_FetchCount <= '0;
            Perf_StallCount <= '0;
        end else begin
            if (pipe_load) begin
                Perf_FetchCount <= Perf_FetchCount + 32'd1;
            end
            if ((state_q == ST_RUN) && ID_Stall && !Redirect_Valid) begin
                Perf_StallCount <= Perf_StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] IM_Address;
    logic [31:0] IM_Instruction;
    logic        ID_Stall;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic [31:0] ID_Instruction;
    logic [31:0] ID_PCPlus4;
    logic        ID_Valid;
    logic        Halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Perf_FetchCount;
    logic [31:0] Perf_StallCount;
`endif

    int errors = 0;
    int checks = 0;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HW)
    ) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .IM_Address      (IM_Address),
        .IM_Instruction  (IM_Instruction),
        .ID_Stall        (ID_Stall),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .ID_Instruction  (ID_Instruction),
        .ID_PCPlus4      (ID_PCPlus4),
        .ID_Valid        (ID_Valid),
        .Halted          (Halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Perf_FetchCount (Perf_FetchCount),
        .Perf_StallCount (Perf_StallCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Combinational instruction memory model.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            32'h0000_0008: return 32'h0000_0033;
            32'h0000_000C: return 32'h0000_0044;
            32'h0000_0010: return HW;
            32'h0000_0040: return 32'h5500_0040;
            32'hFFFF_FFFC: return 32'h7700_00FC;
            default:       return 32'hA000_0000 | a;
        endcase
    endfunction

    assign IM_Instruction = mem_read(IM_Address);

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic        halted;
        logic        ld;
        logic        st;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " addr"},   IM_Address, 32'h0);
        chk({tag, " instr"},  ID_Instruction, 32'h0);
        chk({tag, " pc4"},    ID_PCPlus4, 32'h0);
        chk({tag, " valid"},  {31'b0, ID_Valid}, 32'h0);
        chk({tag, " halted"}, {31'b0, Halted}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ld;
        int exp_st;
        // stall redir target | addr instr pc4 chk_pc4 valid halted | ld st
        tbl[0]  = '{1'b1, 1'b1, 32'h40,        32'h0,         32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h11,        32'h4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,         32'h8,         32'h22,        32'h8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h22,        32'h8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h22,        32'h8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h22,        32'h8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,         32'hC,         32'h33,        32'hC,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 32'h42,        32'h40,        32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,         32'h44,        32'h5500_0040, 32'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'hC,         32'hC,         32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,         32'h10,        32'h44,        32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,         32'h10,        HW,            32'h14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,         32'h10,        HW,            32'h14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,         32'h10,        32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,         32'h10,        32'h0,         32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 32'h0,         32'h0,         32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h11,        32'h4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h7700_00FC, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h11,        32'h4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        Rst_n = 1'b0;
        ID_Stall = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_Target = 32'h0;
        #12;
        chk_reset_vals("reset");
        Rst_n = 1'b1;

        exp_ld = 0;
        exp_st = 0;
        for (int i = 0; i < 20; i++) begin
            ID_Stall        = tbl[i].stall;
            Redirect_Valid  = tbl[i].redir;
            Redirect_Target = tbl[i].tgt;
            step();
            chk($sformatf("v%0d addr", i),   IM_Address, tbl[i].addr);
            chk($sformatf("v%0d instr", i),  ID_Instruction, tbl[i].instr);
            if (tbl[i].chk_pc4) chk($sformatf("v%0d pc4", i), ID_PCPlus4, tbl[i].pc4);
            chk($sformatf("v%0d valid", i),  {31'b0, ID_Valid}, {31'b0, tbl[i].valid});
            chk($sformatf("v%0d halted", i), {31'b0, Halted}, {31'b0, tbl[i].halted});
            if (tbl[i].ld) exp_ld++;
            if (tbl[i].st) exp_st++;
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf fetch", Perf_FetchCount, 32'(exp_ld));
        chk("perf stall", Perf_StallCount, 32'(exp_st));
`endif

        // Async reset between edges with a redirect pending.
        ID_Stall = 1'b0;
        Redirect_Valid = 1'b1;
        Redirect_Target = 32'h80;
        #3;
        Rst_n = 1'b0;
        #1;
        chk_reset_vals("async rst");
`ifdef FETCH_PERF_CNT_EN
        chk("perf fetch rst", Perf_FetchCount, 32'h0);
        chk("perf stall rst", Perf_StallCount, 32'h0);
`endif
        Redirect_Valid = 1'b0;
        step();
        chk_reset_vals("rst held");
        #2;
        Rst_n = 1'b1;
        step();
        chk("boot2 addr",  IM_Address, 32'h0);
        chk("boot2 valid", {31'b0, ID_Valid}, 32'h0);
        step();
        chk("rerun instr", ID_Instruction, 32'h11);
        chk("rerun addr",  IM_Address, 32'h4);

        // Run into the halt word, then reset while halted.
        for (int k = 0; k < 4; k++) step();
        chk("halt2 halted", {31'b0, Halted}, 32'h1);
        chk("halt2 addr",   IM_Address, 32'h10);
        chk("halt2 instr",  ID_Instruction, HW);
        #3;
        Rst_n = 1'b0;
        #1;
        chk_reset_vals("rst halted");
        #2;
        Rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch stage that sits directly upstream of the combinational instruction memory and feeds the ID stage.
- Owns the PC register and drives the instruction-memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles ID stalls, EX-stage branch/jump redirects and a halt word; one instance per core.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; set per core in multicore builds.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch once captured.

Ports:
- Clk  in  1  core clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- IM_Address  out  32  address to instruction memory; equals the PC register.
- IM_Instruction  in  32  word returned combinationally for IM_Address.
- ID_Stall  in  1  hazard unit: hold the PC and the IF/ID register this cycle.
- Redirect_Valid  in  1  taken branch/jump resolved in EX.
- Redirect_Target  in  32  new PC when Redirect_Valid=1.
- ID_Instruction  out  32  IF/ID instruction register.
- ID_PCPlus4  out  32  IF/ID PC+4 of the captured instruction.
- ID_Valid  out  1  IF/ID register holds a real instruction; 0 means bubble.
- Halted  out  1  fetch stopped on HALT_WORD.

Behaviour:
- Clock and reset:
  - Single clock Clk.
  - Rst_n is asynchronous and active-low; assertion takes effect immediately, regardless of Clk.
- Reset values:
  - PC=RESET_PC, ID_Instruction=0, ID_PCPlus4=0, ID_Valid=0, Halted=0.
  - FSM enters BOOT.
- IM_Address = PC register, a direct register output with no logic after the flop.
- Latency: the word at PC appears on ID_Instruction one cycle later, with ID_Valid=1.
- FSM states: BOOT, RUN, HALTED.
- BOOT:
  - Lasts one cycle; ID_Valid stays 0 and PC is held.
  - Then goes to RUN unconditionally, even if Redirect_Valid or ID_Stall is asserted.
- RUN, each edge, checked in priority order:
  1. Redirect_Valid=1:
     - PC<={Redirect_Target[31:2],2'b00}; misaligned targets are silently aligned.
     - IF/ID flushed: ID_Valid<=0, ID_Instruction<=0, ID_PCPlus4<=0.
     - Redirect overrides a simultaneous ID_Stall.
  2. ID_Stall=1: PC and all ID_* outputs hold their values.
  3. Otherwise:
     - ID_Instruction<=IM_Instruction, ID_PCPlus4<=PC+4, ID_Valid<=1.
     - If IM_Instruction==HALT_WORD: PC holds, state<=HALTED, Halted<=1.
     - Else: PC<=PC+4.
- HALTED:
  - PC frozen.
  - The captured halt word stays in IF/ID until ID accepts it (ID_Stall=0). After that, ID_Valid<=0 and ID_Instruction<=0 and they remain so.
  - Redirect_Valid=1 in HALTED (an older branch cancelling the halt) does all of:
    - applies the RUN redirect action;
    - sets Halted<=0;
    - returns the FSM to RUN.
- Arithmetic:
  - PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Aliasing above the memory depth is the memory's concern; the PC is never truncated here.
- Reset mid-operation: reset asserted in any state restores all reset values immediately, including during a pending redirect or halt.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined, add two outputs, Perf_FetchCount[31:0] and Perf_StallCount[31:0]:
  - Perf_FetchCount increments on every cycle that loads ID_Valid<=1.
  - Perf_StallCount increments on every RUN cycle with ID_Stall=1 and Redirect_Valid=0.
  - Both reset to 0 and wrap at 2^32.
- Without the macro: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch-state enum (BOOT, RUN, HALTED);
  - constants PC_STEP=4 and PC_ALIGN_MASK=32'hFFFF_FFFC;
  - default HALT_WORD.
- One natural sub-module, if_id_pipe_reg: the IF/ID register with hold, flush and load controls.
- PC and next-PC logic and the FSM stay in the top.

Test Plan:
- Reset release, RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44:
  - BOOT bubble with ID_Valid=0.
  - Next four cycles: ID_Instruction=0x11,0x22,0x33,0x44 and ID_PCPlus4=4,8,12,16.
- ID_Stall=1 for 3 cycles while PC=8:
  - IM_Address stays 8 and ID_* hold.
  - On release, ID_Instruction=word at 8 and ID_PCPlus4=12.
- Redirect_Valid=1 with target 0x42 together with ID_Stall=1:
  - Next cycle IM_Address=0x40 and ID_Valid=0.
  - Following cycle ID_Instruction=word at 0x40.
- HALT_WORD at address 0x10:
  - After capture, Halted=1 and IM_Address stays 0x10.
  - ID_Valid drops to 0 after ID accepts; a redirect to 0 clears Halted and resumes fetch from 0.
- Rst_n pulsed low mid-run, asynchronously between edges:
  - All outputs return to reset values at once; IM_Address=RESET_PC.
- Redirect to 0xFFFF_FFFC:
  - ID_PCPlus4=0 after capture and the next IM_Address=0.
  - With FETCH_PERF_CNT_EN defined, Perf_FetchCount matches the captured-instruction count.
